// File: rtl/aes_pkg.sv
// Shared constants and FSM encoding for the AES round controller.
package aes_pkg;

    // AES-128 defaults: number of rounds and state/round-key width.
    localparam int unsigned NR = 10;
    localparam int unsigned W  = 128;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StKey0  = 2'd1,
        StRound = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/addRoundKey128.sv
// AddRoundKey step: bitwise XOR of a state word with a round key.
module addRoundKey128 #(
    parameter int unsigned W = 128
) (
    input  logic [W-1:0] word,
    input  logic [W-1:0] key,
    output logic [W-1:0] result
);

    assign result = word ^ key;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequences one AES encryption: initial key whitening, NR rounds through an
// external round datapath, and handshaking with an external key schedule.
module aes_round_ctrl #(
    parameter int unsigned NR = aes_pkg::NR,
    parameter int unsigned W  = aes_pkg::W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] text_in,
    output logic         ready,
    output logic         rk_req,
    output logic [3:0]   rk_idx,
    input  logic         rk_valid,
    input  logic [W-1:0] rk_data,
    output logic [W-1:0] rnd_in,
    output logic         rnd_last,
    input  logic [W-1:0] rnd_out,
    output logic [W-1:0] text_out,
    output logic         done,
    input  logic         abort
);

    import aes_pkg::*;

    localparam logic [3:0] LastRound = 4'(NR);

    state_e       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [W-1:0] data_q, data_d;
    logic [W-1:0] text_q, text_d;
    logic [W-1:0] ark_in, ark_out;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: cipher state, round counter, ciphertext
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            round_q <= 4'd0;
            text_q  <= '0;
        end else begin
            data_q  <= data_d;
            round_q <= round_d;
            text_q  <= text_d;
        end
    end

    // Next-state logic; abort outranks a key arriving in the same cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StKey0;
                end
            end
            StKey0: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (rk_valid) begin
                    state_d = StRound;
                end
            end
            StRound: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (rk_valid && (round_q == LastRound)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath next values; registers only move when a key is consumed
    always_comb begin
        data_d  = data_q;
        round_d = round_q;
        text_d  = text_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    data_d  = text_in;
                    round_d = 4'd0;
                end
            end
            StKey0: begin
                if (!abort && rk_valid) begin
                    data_d  = ark_out;
                    round_d = 4'd1;
                end
            end
            StRound: begin
                if (!abort && rk_valid) begin
                    data_d = ark_out;
                    // Counter saturates at the last round; it never wraps
                    if (round_q == LastRound) begin
                        text_d = ark_out;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Whitening XORs the raw state; later rounds XOR the round datapath result
    assign ark_in = (state_q == StKey0) ? data_q : rnd_out;

    addRoundKey128 #(
        .W(W)
    ) u_ark (
        .word   (ark_in),
        .key    (rk_data),
        .result (ark_out)
    );

    // Output decode from the current state
    always_comb begin
        ready    = (state_q == StIdle);
        rk_req   = (state_q == StKey0) || (state_q == StRound);
        rk_idx   = (state_q == StRound) ? round_q : 4'd0;
        rnd_last = (state_q == StRound) && (round_q == LastRound);
        done     = (state_q == StDone);
    end

    assign rnd_in   = data_q;
    assign text_out = text_q;

endmodule
